// File: rtl/lock_entry_ctrl_pkg.sv
// Shared types and defaults for the keypad lock controller.
// The state encoding is visible to the outside world through state_leds.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'b000,
        ST_ENTRY    = 3'b001,
        ST_CHECK    = 3'b010,
        ST_UNLOCKED = 3'b011,
        ST_ERROR    = 3'b100,
        ST_LOCKOUT  = 3'b101,
        ST_PROGRAM  = 3'b110
    } lock_state_t;

    localparam int          DEF_CODE_LEN    = 4;
    localparam int          DEF_MAX_TRIES   = 3;
    localparam int          DEF_ERR_CYC     = 8;
    localparam int          DEF_LOCKOUT_CYC = 1024;
    localparam int          DEF_TIMEOUT_CYC = 4096;
    localparam logic [15:0] DEF_RESET_CODE  = 16'h1234;
    localparam logic [3:0]  DIGIT_MAX       = 4'd9;

    function automatic logic digit_valid(input logic [3:0] digit);
        return digit <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/lock_entry_ctrl_if.sv
// Keypad inputs and indicator outputs of the lock controller bundled as one port.
// The keypad side drives through master, the controller sits on slave.
interface lock_entry_ctrl_if;

    logic [3:0] digit_in;
    logic       enter_btn;
    logic       relock;
    logic       prog_btn;
    logic       locked_led;
    logic       unlocked_led;
    logic       error_led;
    logic [2:0] state_leds;
    logic [1:0] tries_left;
    logic       lockout_active;

    modport master (
        output digit_in, enter_btn, relock, prog_btn,
        input  locked_led, unlocked_led, error_led, state_leds, tries_left, lockout_active
    );

    modport slave (
        input  digit_in, enter_btn, relock, prog_btn,
        output locked_led, unlocked_led, error_led, state_leds, tries_left, lockout_active
    );

endinterface

// File: rtl/lock_entry_ctrl_btn_sync_edge.sv
// Brings a raw button level into the clk domain and emits one pulse per press.
// The third flop holds the previous synchronized level for edge detection.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/lock_entry_ctrl.sv
// Keypad lock: collects a BCD code, compares it, limits failed attempts with
// an error hold-off and a lockout, and lets an unlocked user reprogram the code.
module lock_entry_ctrl
    import lock_pkg::*;
#(
    parameter int                    CODE_LEN    = DEF_CODE_LEN,
    parameter int                    MAX_TRIES   = DEF_MAX_TRIES,
    parameter int                    ERR_CYC     = DEF_ERR_CYC,
    parameter int                    LOCKOUT_CYC = DEF_LOCKOUT_CYC,
    parameter int                    TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [4*CODE_LEN-1:0] RESET_CODE  = DEF_RESET_CODE
) (
    input  logic             clk,
    input  logic             rst_n,
    lock_entry_ctrl_if.slave bus
);

    localparam int BW   = 4 * CODE_LEN;
    localparam int CW   = $clog2(CODE_LEN) + 1;
    localparam int TMAX = (ERR_CYC > LOCKOUT_CYC)
                        ? ((ERR_CYC > TIMEOUT_CYC) ? ERR_CYC : TIMEOUT_CYC)
                        : ((LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC : TIMEOUT_CYC);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0] LAST_SLOT    = CW'(CODE_LEN - 1);
    localparam logic [1:0]    TRIES_FULL   = 2'(MAX_TRIES);
    localparam logic [TW-1:0] ERR_LAST     = TW'(ERR_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    lock_state_t   state;
    logic [BW-1:0] code_reg;
    logic [BW-1:0] entry_buf;
    logic [BW-1:0] shadow_buf;
    logic [BW-1:0] entry_ins;
    logic [BW-1:0] shadow_ins;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [1:0]    tries;
    logic          invalid;
    logic          press;
    logic          digit_ok;

    btn_sync_edge u_enter_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.enter_btn),
        .pulse (press)
    );

    assign digit_ok = digit_valid(bus.digit_in);

    // Buffers with the current digit dropped into slot cnt; slot 0 is the MSB nibble.
    always_comb begin
        entry_ins  = entry_buf;
        shadow_ins = shadow_buf;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (cnt == CW'(i)) begin
                entry_ins[BW-1-4*i -: 4]  = bus.digit_in;
                shadow_ins[BW-1-4*i -: 4] = bus.digit_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_LOCKED;
            code_reg   <= RESET_CODE;
            tries      <= TRIES_FULL;
            entry_buf  <= '0;
            shadow_buf <= '0;
            cnt        <= '0;
            timer      <= '0;
            invalid    <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (press) begin
                        entry_buf          <= '0;
                        entry_buf[BW-1 -: 4] <= bus.digit_in;
                        cnt                <= CW'(1);
                        timer              <= '0;
                        invalid            <= ~digit_ok;
                        state              <= (!digit_ok || CODE_LEN == 1) ? ST_CHECK : ST_ENTRY;
                    end
                end

                ST_ENTRY: begin
                    if (press) begin
                        entry_buf <= entry_ins;
                        cnt       <= cnt + CW'(1);
                        timer     <= '0;
                        if (!digit_ok) begin
                            invalid <= 1'b1;
                            state   <= ST_CHECK;
                        end else if (cnt == LAST_SLOT) begin
                            state <= ST_CHECK;
                        end
                    end else if (timer == TIMEOUT_LAST) begin
                        entry_buf <= '0;
                        cnt       <= '0;
                        timer     <= '0;
                        state     <= ST_LOCKED;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                // The buffer is wiped here so a typed code never lingers past the compare.
                ST_CHECK: begin
                    entry_buf <= '0;
                    cnt       <= '0;
                    timer     <= '0;
                    if (!invalid && entry_buf == code_reg) begin
                        tries <= TRIES_FULL;
                        state <= ST_UNLOCKED;
                    end else begin
                        tries <= (tries != 2'd0) ? tries - 2'd1 : 2'd0;
                        state <= (tries <= 2'd1) ? ST_LOCKOUT : ST_ERROR;
                    end
                end

                ST_ERROR: begin
                    if (timer == ERR_LAST) begin
                        timer <= '0;
                        state <= ST_LOCKED;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == LOCKOUT_LAST) begin
                        timer <= '0;
                        tries <= TRIES_FULL;
                        state <= ST_LOCKED;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ST_UNLOCKED: begin
                    if (bus.relock) begin
                        state <= ST_LOCKED;
                    end else if (bus.prog_btn) begin
                        shadow_buf <= '0;
                        cnt        <= '0;
                        state      <= ST_PROGRAM;
                    end
                end

                // The code register is only touched once the full shadow code is in hand.
                ST_PROGRAM: begin
                    if (bus.relock) begin
                        shadow_buf <= '0;
                        cnt        <= '0;
                        state      <= ST_LOCKED;
                    end else if (press) begin
                        if (!digit_ok) begin
                            shadow_buf <= '0;
                            cnt        <= '0;
                            state      <= ST_UNLOCKED;
                        end else if (cnt == LAST_SLOT) begin
                            code_reg   <= shadow_ins;
                            shadow_buf <= '0;
                            cnt        <= '0;
                            state      <= ST_UNLOCKED;
                        end else begin
                            shadow_buf <= shadow_ins;
                            cnt        <= cnt + CW'(1);
                        end
                    end
                end

                default: begin
                    cnt   <= '0;
                    timer <= '0;
                    state <= ST_LOCKED;
                end
            endcase
        end
    end

    assign bus.state_leds     = state;
    assign bus.tries_left     = tries;
    assign bus.locked_led     = state inside {ST_LOCKED, ST_ENTRY, ST_CHECK, ST_ERROR, ST_LOCKOUT};
    assign bus.unlocked_led   = state inside {ST_UNLOCKED, ST_PROGRAM};
    assign bus.error_led      = state inside {ST_ERROR, ST_LOCKOUT};
    assign bus.lockout_active = (state == ST_LOCKOUT);

endmodule
